// File: rtl/conv_tree_deserializer_16.sv
// Serial-to-parallel receiver: hunts for the sync word, tracks frame alignment
// and emits each data word, optionally in the serializer's bit-reversed order.
`timescale 1ns/1ps
module conv_tree_deserializer_16 #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD   = 16'hF628,
  parameter int unsigned      FRAME_WORDS = 4,
  parameter int unsigned      LOCK_MISSES = 2,
  parameter int unsigned      TREE_ORDER  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             PAR_VALID,
  output logic             LOCKED,
  output logic             SYNC_ERR
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    FW       = 8'(FRAME_WORDS);
  localparam logic [3:0]    LM       = 4'(LOCK_MISSES);

  typedef enum logic {HUNT, LOCK} state_t;

  function automatic int bitrev(input int idx);
    int r;
    r = 0;
    for (int b = 0; b < CW; b++) begin
      if (idx[b]) r = r | (1 << (CW - 1 - b));
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  // Only the newest WIDTH-1 bits are kept; the incoming bit completes the word.
  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d, miss_inc;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [WIDTH-1:0] word_perm;

  assign sr_d     = {SERIAL_IN, sr_q};
  assign miss_inc = miss_cnt_q + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_perm
      if (TREE_ORDER != 0) begin : g_tree
        assign word_perm[gi] = sr_d[bitrev(gi)];
      end else begin : g_nat
        assign word_perm[gi] = sr_d[gi];
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    par_out_d   = par_out_q;
    par_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    case (state_q)
      HUNT: begin
        if (sr_d == SYNC_WORD) begin
          state_d    = LOCK;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          miss_cnt_d = '0;
        end
      end
      LOCK: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          if (word_cnt_q != FW) begin
            par_out_d   = word_perm;
            par_valid_d = 1'b1;
            word_cnt_d  = word_cnt_q + 8'd1;
          end else begin
            // Sync slot: never realign while locked, only count misses.
            word_cnt_d = '0;
            if (sr_d == SYNC_WORD) begin
              miss_cnt_d = '0;
            end else begin
              sync_err_d = 1'b1;
              miss_cnt_d = miss_inc;
              if (miss_inc >= LM) state_d = HUNT;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d[WIDTH-1:1];
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign PAR_OUT   = par_out_q;
  assign PAR_VALID = par_valid_q;
  assign LOCKED    = (state_q == LOCK);
  assign SYNC_ERR  = sync_err_q;

endmodule

// File: doc/conv_tree_deserializer_16.md
Name: conv_tree_deserializer_16

Overview:
- Receive-side counterpart of the tree serializer: recovers 16-bit parallel words from a single-bit serial stream.
- Hunts for a sync word, locks frame alignment and emits each data word with a one-cycle valid strobe.
- Optionally re-applies the serializer's bit-reversed tree input ordering.
- Sits at the link receiver, feeding parallel consumers in the same CLK domain.

Parameters:
- WIDTH, 16, word width; power of two, at least 4.
- SYNC_WORD, 16'hF628, frame marker; serial LSB-first like data.
- FRAME_WORDS, 4, data words between consecutive sync words; 1 to 255.
- LOCK_MISSES, 2, consecutive bad sync slots before lock is dropped; 1 to 15.
- TREE_ORDER, 1, 1 = PAR_OUT[i] carries received bit bitrev(i); 0 = natural order.

Ports:
- CLK  input  1  clock; SERIAL_IN sampled on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- SERIAL_IN  input  1  serial data, one bit per CLK, LSB (first bit) first.
- PAR_OUT  output  WIDTH  last recovered data word; holds between strobes.
- PAR_VALID  output  1  one-cycle strobe: PAR_OUT updated this cycle.
- LOCKED  output  1  high while frame-aligned.
- SYNC_ERR  output  1  one-cycle strobe: a sync slot held a non-sync word while locked.

Behaviour:
- Reset (RESET=0, async): shift reg, counters, PAR_OUT=0, PAR_VALID=0, LOCKED=0, SYNC_ERR=0, state=HUNT. Also applies mid-word or mid-frame; on release, hunting restarts with an empty shift reg.
- Shift reg: each rising edge, sr <= {SERIAL_IN, sr[WIDTH-1:1]}. sr_next is that value. The first bit of a word ends in bit 0.
- HUNT:
  - Compare sr_next to SYNC_WORD every cycle.
  - Match: go to LOCKED. Set bit_cnt=0, word_cnt=0, miss_cnt=0, LOCKED=1 from the next cycle.
  - Sync words never produce PAR_VALID.
- LOCKED:
  - bit_cnt increments 0..WIDTH-1 and wraps.
  - At the edge sampling bit WIDTH-1, sr_next is a complete word w.
  - Data slot (word_cnt < FRAME_WORDS):
    - Register PAR_OUT <= perm(w), or w if TREE_ORDER=0. PAR_VALID=1 for that cycle.
    - Latency: PAR_OUT/PAR_VALID visible in the cycle after the edge that sampled the word's last bit.
    - word_cnt++.
  - Sync slot (word_cnt == FRAME_WORDS):
    - w == SYNC_WORD: miss_cnt=0, no strobe.
    - Otherwise: SYNC_ERR=1 for one cycle, word discarded, miss_cnt++.
    - If miss_cnt reaches LOCK_MISSES: return to HUNT, LOCKED=0 next cycle.
    - word_cnt=0 in all cases (realignment is not attempted while locked).
- perm(w)[i] = w[bitrev_log2(WIDTH)(i)], matching the serializer's tree input mapping. For WIDTH=16: 0<-0, 1<-8, 2<-4, 3<-12, 4<-2, 5<-10, 6<-6, 7<-14, 8<-1, 9<-9, 10<-5, 11<-13, 12<-3, 13<-11, 14<-7, 15<-15.
- A data word equal to SYNC_WORD in a data slot is output normally.
- False sync in HUNT is resolved only by the miss mechanism.
- PAR_VALID and SYNC_ERR never assert in the same cycle. Neither asserts in HUNT.
- No backpressure: the consumer must accept every strobe.

Test Plan:
- Reset: drive RESET=0 mid-stream with random SERIAL_IN -> all outputs 0 immediately (async) and while held. After release, LOCKED stays 0 until a full sync is received.
- Lock and decode (TREE_ORDER=1): send F628, then C5AF, 0000, FFFF, 1234, then F628, all LSB-first.
  - LOCKED rises the cycle after the sync's last bit.
  - First PAR_VALID fires 16 cycles later with PAR_OUT=16'hD5B3, followed by 0000, FFFF and perm(1234).
  - No SYNC_ERR.
- Natural order (TREE_ORDER=0): same stream -> first word PAR_OUT=16'hC5AF. Strobes are spaced exactly 16 cycles apart, with a 16-cycle gap over the sync slot.
- Sync miss and recovery: lock, then replace one sync slot with 16'h0000.
  - SYNC_ERR pulses once and LOCKED stays 1.
  - The next frame with a correct sync clears the miss count, and data continues.
- Lock loss: lock, then corrupt 2 consecutive sync slots -> SYNC_ERR on both, LOCKED falls after the second. Following data produces no PAR_VALID until a fresh F628 is seen.
- Random: 10 frames of $random data with a reset pulse mid-frame -> the scoreboard matches every word, with no strobes between reset and relock.
